// File: rtl/j1_uart.sv
// Memory-mapped 8N1 UART for the J1 I/O bus: DATA at BASE_ADDR, STATUS at BASE_ADDR+2.
// TX and RX bytes are buffered in small circular FIFOs so polling code never loses data.
module j1_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dat_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  // A pop on a full FIFO frees the slot the push is about to reuse.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= dat_i;
  end
endmodule

module j1_uart #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'h5000
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          txd_q;

  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [1:0]    rx_sync_q;
  logic          overrun_q, frame_err_q;

  logic       sel_data, sel_stat;
  logic       tx_push, tx_pop, tx_empty, tx_full, tx_idle;
  logic       rx_push, rx_pop, rx_empty, rx_full, rx_s;
  logic [7:0] tx_head, rx_head;
  logic       unused_dout;

  assign sel_data    = (io_addr == BASE_ADDR);
  assign sel_stat    = (io_addr == BASE_ADDR + 16'd2);
  assign unused_dout = ^io_dout[15:8];

  assign tx_push = io_wr && sel_data;
  assign tx_pop  = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                 (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST));
  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);

  assign rx_s    = rx_sync_q[1];
  assign rx_pop  = io_rd && sel_data && !rx_empty;
  assign rx_push = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_s;

  j1_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk_i(sys_clk_i), .rst_i(sys_rst_i), .push_i(tx_push), .pop_i(tx_pop),
    .dat_i(io_dout[7:0]), .dat_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );

  j1_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk_i(sys_clk_i), .rst_i(sys_rst_i), .push_i(rx_push), .pop_i(rx_pop),
    .dat_i(rx_shift_q), .dat_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );

  always_comb begin
    io_din = 16'h0000;
    if (sel_data)      io_din = {8'h00, rx_head};
    else if (sel_stat) io_din = {11'b0, frame_err_q, overrun_q, tx_full, tx_idle, !rx_empty};
  end

  assign uart_txd = txd_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (!tx_empty) begin
            tx_shift_q <= tx_head;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else tx_cnt_q <= tx_cnt_q + CW'(1);
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
            end
          end else tx_cnt_q <= tx_cnt_q + CW'(1);
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (!tx_empty) begin
              tx_shift_q <= tx_head;
              txd_q      <= 1'b0;
              tx_state_q <= TX_START;
            end else tx_state_q <= TX_IDLE;
          end else tx_cnt_q <= tx_cnt_q + CW'(1);
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) rx_sync_q <= 2'b11;
    else           rx_sync_q <= {rx_sync_q[0], uart_rxd};
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (io_wr && sel_stat && io_dout[3]) overrun_q   <= 1'b0;
      if (io_wr && sel_stat && io_dout[4]) frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == BIT_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_s) begin
              if (rx_full && !rx_pop) overrun_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= RX_WAIT;
            end
          end else rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        RX_WAIT: if (rx_s) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
endmodule
